core_quant_pack: RTL and testbench

Output stage directly downstream of the core accumulator. Takes each finished signed partial-sum word, requantizes it to a signed ODATA_BIT value (multiply by scale, round, shift, add zero point, saturate), and packs PACK_NUM results into one output word. Packed words go into a small first-word-fall-through FIFO with a valid/ready handshake toward the writeback path. The accumulator cannot be back-pressured, so FIFO overflow is reported, not stalled.

---
 rtl/core_quant_pack.sv | 186 ++++++++++++++++++
 tb/tb_core_quant_pack.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_quant_pack.sv
// ---------------------------------------------------------------------------
// core_quant_pack
//
// Output stage behind the core accumulator. Each signed partial sum is
// requantized to a signed ODATA_BIT lane:
//   multiply by scale -> round-half-up shift -> add zero point -> saturate
// PACK_NUM lanes are packed into one word. Words go into a small FWFT FIFO
// toward the writeback path. The accumulator cannot be stalled, so a word
// that arrives at a full FIFO is dropped and reported on the sticky ovf flag.
//
// Ports:
//   clk, rstn         clock (rising edge), asynchronous active-low reset
//   cfg_quant_scale   unsigned requant multiplier        (quasi-static)
//   cfg_quant_shift   rounding arithmetic right shift    (quasi-static)
//   cfg_quant_zp      signed zero point                  (quasi-static)
//   idata/idata_valid signed accumulator value and its qualifier
//   pack_flush        close the partial word after any same-cycle idata
//   odata/odata_valid packed head-of-FIFO word, lane i at [i*ODATA_BIT +: ODATA_BIT]
//   odata_ready       consumer accepts the head word
//   ovf               sticky: a packed word was dropped on a full FIFO
//
// PACK_NUM >= 2 and FIFO_DEPTH a power of two >= 2.
// ---------------------------------------------------------------------------
module core_quant_pack #(
  parameter int IDATA_WIDTH = 25,
  parameter int SCALE_WIDTH = 16,
  parameter int SHIFT_WIDTH = 5,
  parameter int ODATA_BIT   = 8,
  parameter int PACK_NUM    = 4,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [SCALE_WIDTH-1:0]        cfg_quant_scale,
  input  logic [SHIFT_WIDTH-1:0]        cfg_quant_shift,
  input  logic [ODATA_BIT-1:0]          cfg_quant_zp,
  input  logic [IDATA_WIDTH-1:0]        idata,
  input  logic                          idata_valid,
  input  logic                          pack_flush,
  output logic [PACK_NUM*ODATA_BIT-1:0] odata,
  output logic                          odata_valid,
  input  logic                          odata_ready,
  output logic                          ovf
);

  // Exact product width, plus two guard bits so the rounding add and the
  // zero-point add can never wrap.
  localparam int PW = IDATA_WIDTH + SCALE_WIDTH + 1;
  localparam int VW = PW + 2;
  localparam int OW = PACK_NUM * ODATA_BIT;
  localparam int LW = $clog2(PACK_NUM);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic signed [VW-1:0] QMAX = {{(VW-ODATA_BIT+1){1'b0}}, {(ODATA_BIT-1){1'b1}}};
  localparam logic signed [VW-1:0] QMIN = {{(VW-ODATA_BIT+1){1'b1}}, {(ODATA_BIT-1){1'b0}}};

  // -------------------------------------------------------------------------
  // S1: exact signed x unsigned multiply
  // -------------------------------------------------------------------------
  logic signed [PW-1:0] mul_a, mul_b;
  logic signed [PW-1:0] s1_prod;
  logic                 s1_valid, s1_flush;

  // Scale gets a zero MSB so it multiplies as a non-negative signed value.
  assign mul_a = PW'($signed(idata));
  assign mul_b = PW'($signed({1'b0, cfg_quant_scale}));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_prod  <= '0;
      s1_valid <= 1'b0;
      s1_flush <= 1'b0;
    end else begin
      s1_valid <= idata_valid;
      s1_flush <= pack_flush;
      if (idata_valid) s1_prod <= mul_a * mul_b;
    end
  end

  // -------------------------------------------------------------------------
  // S2: round-half-up shift, zero point, saturate
  // -------------------------------------------------------------------------
  logic signed [VW-1:0]  prod_ext, rnd, rsh, v_full;
  logic [ODATA_BIT-1:0]  q_sat;
  logic [ODATA_BIT-1:0]  s2_data;
  logic                  s2_valid, s2_flush;

  // NOTE: combinational blocks use blocking assignments and give every
  // output a default first, so no path leaves a value held (no latch).
  always_comb begin
    prod_ext = VW'(s1_prod);
    rnd      = '0;
    if (cfg_quant_shift != '0)
      rnd = VW'(1) << (cfg_quant_shift - SHIFT_WIDTH'(1));
    rsh    = (prod_ext + rnd) >>> cfg_quant_shift;
    v_full = rsh + VW'($signed(cfg_quant_zp));
    q_sat  = v_full[ODATA_BIT-1:0];
    if (v_full > QMAX)      q_sat = QMAX[ODATA_BIT-1:0];
    else if (v_full < QMIN) q_sat = QMIN[ODATA_BIT-1:0];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s2_data  <= '0;
      s2_valid <= 1'b0;
      s2_flush <= 1'b0;
    end else begin
      s2_valid <= s1_valid;
      s2_flush <= s1_flush;
      if (s1_valid) s2_data <= q_sat;
    end
  end

  // -------------------------------------------------------------------------
  // Pack stage
  // -------------------------------------------------------------------------
  logic [OW-1:0] pack_reg;
  logic [LW-1:0] lane_cnt;
  logic [OW-1:0] word_next;
  logic          lane_last;
  logic          push;

  // word_next is the word including this cycle's value; it is both the
  // pushed word and the next pack_reg when nothing is pushed.
  always_comb begin
    word_next = pack_reg;
    if (s2_valid) word_next[lane_cnt*ODATA_BIT +: ODATA_BIT] = s2_data;
    lane_last = s2_valid && (lane_cnt == LW'(PACK_NUM - 1));
    // A flush pushes only if at least one lane (counting this cycle's value)
    // is filled; a flush that coincides with a full word folds into it.
    push      = lane_last || (s2_flush && (s2_valid || (lane_cnt != '0)));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pack_reg <= '0;
      lane_cnt <= '0;
    end else if (push) begin
      pack_reg <= '0;
      lane_cnt <= '0;
    end else if (s2_valid) begin
      pack_reg <= word_next;
      lane_cnt <= lane_cnt + LW'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Output FIFO (first-word-fall-through)
  // -------------------------------------------------------------------------
  logic [OW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          pop, fifo_full, wr_en;

  assign pop       = odata_valid && odata_ready;
  assign fifo_full = (count == CW'(FIFO_DEPTH));
  // On a full FIFO a simultaneous pop frees the slot, so the push is kept.
  assign wr_en     = push && (!fifo_full || pop);

  // NOTE: the storage array has no reset; only pointers and count do, and
  // odata is masked while empty, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= word_next;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(wr_en) - CW'(pop);
      if (push && fifo_full && !pop) ovf <= 1'b1;
    end
  end

  assign odata_valid = (count != '0);
  assign odata       = odata_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_core_quant_pack.sv
// ---------------------------------------------------------------------------
// tb_core_quant_pack: directed self-checking bench for core_quant_pack.
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_core_quant_pack;

  localparam int IW = 25;
  localparam int SW = 16;
  localparam int HW = 5;
  localparam int OB = 8;
  localparam int PN = 4;
  localparam int FD = 4;
  localparam int OW = PN * OB;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [SW-1:0] cfg_quant_scale = '0;
  logic [HW-1:0] cfg_quant_shift = '0;
  logic [OB-1:0] cfg_quant_zp = '0;
  logic [IW-1:0] idata = '0;
  logic          idata_valid = 1'b0;
  logic          pack_flush = 1'b0;
  logic [OW-1:0] odata;
  logic          odata_valid;
  logic          odata_ready = 1'b0;
  logic          ovf;

  int checks = 0;
  int errors = 0;

  core_quant_pack #(
    .IDATA_WIDTH(IW), .SCALE_WIDTH(SW), .SHIFT_WIDTH(HW),
    .ODATA_BIT(OB), .PACK_NUM(PN), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rstn(rstn),
    .cfg_quant_scale(cfg_quant_scale), .cfg_quant_shift(cfg_quant_shift),
    .cfg_quant_zp(cfg_quant_zp),
    .idata(idata), .idata_valid(idata_valid), .pack_flush(pack_flush),
    .odata(odata), .odata_valid(odata_valid), .odata_ready(odata_ready),
    .ovf(ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers (no comparisons inside) ----------------
  task automatic drive(input int v, input bit vld, input bit fl);
    @(negedge clk);
    idata       = v[IW-1:0];
    idata_valid = vld;
    pack_flush  = fl;
  endtask

  task automatic idle();
    drive(0, 1'b0, 1'b0);
  endtask

  task automatic set_cfg(input int scale, input int shift, input int zp);
    @(negedge clk);
    cfg_quant_scale = scale[SW-1:0];
    cfg_quant_shift = shift[HW-1:0];
    cfg_quant_zp    = zp[OB-1:0];
  endtask

  // Waits (bounded) for a word, returns it and pops it.
  task automatic pop_word(output logic [OW-1:0] w, output bit ok);
    ok = 1'b0;
    w  = '0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (odata_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      w = odata;
      odata_ready = 1'b1;
      @(negedge clk);
      odata_ready = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    idata_valid = 1'b0;
    pack_flush = 1'b0;
    odata_ready = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    checks++;
    if (odata !== '0 || odata_valid !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: odata=%h valid=%b ovf=%b, want 0/0/0", odata, odata_valid, ovf);
    end
  endtask

  task automatic test_pack_order();
    set_cfg(1, 0, 0);
    drive(1, 1, 0); drive(2, 1, 0); drive(3, 1, 0); drive(4, 1, 0);
    idle();
    @(negedge clk);
    checks++;
    if (odata_valid !== 1'b0) begin
      errors++;
      $display("FAIL pack_latency_early: valid=%b at t+2, want 0", odata_valid);
    end
    @(negedge clk);
    checks++;
    if (odata_valid !== 1'b1 || odata !== 32'h04030201) begin
      errors++;
      $display("FAIL pack_order: valid=%b odata=%h at t+3, want 1/04030201", odata_valid, odata);
    end
    odata_ready = 1'b1;
    @(negedge clk);
    odata_ready = 1'b0;
    checks++;
    if (odata_valid !== 1'b0) begin
      errors++;
      $display("FAIL pack_drained: valid=%b, want 0", odata_valid);
    end
  endtask

  task automatic test_rounding();
    logic [OW-1:0] w;
    bit ok;
    set_cfg(1, 1, 0);
    drive(3, 1, 0); drive(-3, 1, 0); drive(5, 1, 0); drive(-5, 1, 0);
    idle();
    pop_word(w, ok);
    checks++;
    if (!ok || w !== 32'hFE03FF02) begin
      errors++;
      $display("FAIL rounding: got=%h ok=%b, want FE03FF02", w, ok);
    end
  endtask

  task automatic test_saturation();
    logic [OW-1:0] w;
    bit ok;
    set_cfg(1, 0, -5);
    drive(1000, 1, 0); drive(-1000, 1, 0); drive(0, 1, 0); drive(132, 1, 0);
    idle();
    pop_word(w, ok);
    checks++;
    if (!ok || w !== 32'h7FFB807F) begin
      errors++;
      $display("FAIL saturation_zp: got=%h ok=%b, want 7FFB807F", w, ok);
    end
  endtask

  task automatic test_scale();
    logic [OW-1:0] w;
    bit ok;
    set_cfg(300, 8, 0);
    drive(100, 1, 0); drive(0, 1, 0); drive(0, 1, 0); drive(0, 1, 0);
    idle();
    pop_word(w, ok);
    checks++;
    if (!ok || w !== 32'h00000075) begin
      errors++;
      $display("FAIL scale: got=%h ok=%b, want 00000075", w, ok);
    end
  endtask

  task automatic test_flush();
    logic [OW-1:0] w;
    bit ok;
    bit seen;
    set_cfg(1, 0, 0);
    // Partial word closed by a lone flush: latency t+3 from the flush cycle.
    drive(5, 1, 0); drive(6, 1, 0); drive(0, 0, 1);
    idle();
    @(negedge clk);
    checks++;
    if (odata_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_latency_early: valid=%b at t+2, want 0", odata_valid);
    end
    @(negedge clk);
    checks++;
    if (odata_valid !== 1'b1 || odata !== 32'h00000605) begin
      errors++;
      $display("FAIL flush_partial: valid=%b odata=%h, want 1/00000605", odata_valid, odata);
    end
    odata_ready = 1'b1;
    @(negedge clk);
    odata_ready = 1'b0;
    // Flush with nothing pending pushes nothing.
    drive(0, 0, 1);
    idle();
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (odata_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL flush_empty: word appeared=%b, want 0", seen);
    end
    // Fourth value with a same-cycle flush: exactly one full word.
    drive(7, 1, 0); drive(8, 1, 0); drive(9, 1, 0); drive(10, 1, 1);
    idle();
    pop_word(w, ok);
    checks++;
    if (!ok || w !== 32'h0A090807) begin
      errors++;
      $display("FAIL flush_full_word: got=%h ok=%b, want 0A090807", w, ok);
    end
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (odata_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL flush_single_push: extra word=%b, want 0", seen);
    end
    // Value plus same-cycle flush counts as pending data.
    drive(11, 1, 0); drive(12, 1, 1);
    idle();
    pop_word(w, ok);
    checks++;
    if (!ok || w !== 32'h00000C0B) begin
      errors++;
      $display("FAIL flush_same_cycle: got=%h ok=%b, want 00000C0B", w, ok);
    end
  endtask

  task automatic test_back_to_back();
    logic [OW-1:0] exp_w [4];
    exp_w[0] = 32'h04030201;
    exp_w[1] = 32'h14131211;
    exp_w[2] = 32'h24232221;
    exp_w[3] = 32'h34333231;
    set_cfg(1, 0, 0);
    odata_ready = 1'b0;
    for (int k = 0; k < 5; k++)
      for (int i = 0; i < PN; i++)
        drive(16 * k + i + 1, 1, 0);
    idle();
    @(negedge clk);
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL ovf_early: ovf=%b before 5th push lands, want 0", ovf);
    end
    @(negedge clk);
    checks++;
    if (ovf !== 1'b1 || odata_valid !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set: ovf=%b valid=%b, want 1/1", ovf, odata_valid);
    end
    // Head is held while not ready.
    repeat (3) @(negedge clk);
    checks++;
    if (odata !== exp_w[0]) begin
      errors++;
      $display("FAIL hold_stable: odata=%h, want %h", odata, exp_w[0]);
    end
    odata_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (odata_valid !== 1'b1 || odata !== exp_w[k]) begin
        errors++;
        $display("FAIL drain_word%0d: valid=%b odata=%h, want 1/%h", k, odata_valid, odata, exp_w[k]);
      end
      @(negedge clk);
    end
    odata_ready = 1'b0;
    checks++;
    if (odata_valid !== 1'b0 || ovf !== 1'b1) begin
      errors++;
      $display("FAIL drain_end: valid=%b ovf=%b, want 0/1", odata_valid, ovf);
    end
    do_reset();
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear: ovf=%b after reset, want 0", ovf);
    end
  endtask

  task automatic test_reset_mid();
    logic [OW-1:0] w;
    bit ok;
    bit seen;
    set_cfg(1, 0, 0);
    drive(1, 1, 0); drive(2, 1, 0); drive(3, 1, 0);
    @(negedge clk);
    idata_valid = 1'b0;
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (odata_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_no_output: word appeared=%b, want 0", seen);
    end
    drive(17, 1, 0); drive(18, 1, 0); drive(19, 1, 0); drive(20, 1, 0);
    idle();
    pop_word(w, ok);
    checks++;
    if (!ok || w !== 32'h14131211) begin
      errors++;
      $display("FAIL reset_mid_clean_word: got=%h ok=%b, want 14131211", w, ok);
    end
  endtask

  initial begin
    test_reset();
    test_pack_order();
    test_rounding();
    test_saturation();
    test_scale();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
